// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and helpers for the multiply/divide unit
package mdu_pkg;
   localparam int MDU_MAX_W = 128;
   typedef enum logic [1:0] {
      MDU_MULT = 2'b00,
      MDU_DIV  = 2'b01,
      MDU_MTHI = 2'b10,
      MDU_MTLO = 2'b11
   } mdu_op_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} mdu_state_t;
   // Callers zero-extend the operand and truncate the result back to their width.
   function automatic logic [MDU_MAX_W-1:0] twos_mag(input logic [MDU_MAX_W-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one shift-add multiply or restoring-divide iteration
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic               mode,
   input  logic [2*WIDTH:0]   acc,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH:0]   next_acc,
   output logic               qbit
);
   logic [WIDTH:0]   sum, trial;
   logic [2*WIDTH:0] shl, add;
   always_comb begin
      sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
      add      = {sum, acc[WIDTH-1:0]} >> 1;
      shl      = acc << 1;
      qbit     = mode && (shl[2*WIDTH:WIDTH] >= {1'b0, operand});
      trial    = shl[2*WIDTH:WIDTH] - {1'b0, operand};
      // quotient bit is left clear here and merged in by the caller
      next_acc = mode ? {qbit ? trial : shl[2*WIDTH:WIDTH], shl[WIDTH-1:0]} : add;
   end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply/divide with HI/LO registers
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             unsig,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   mdu_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH:0]   acc, step_acc;
   logic [WIDTH-1:0]   opnd, a_orig, mag_a, mag_b, quot, rem;
   logic [2*WIDTH-1:0] raw, prod;
   logic               is_div, neg_p, neg_r, qbit;

   assign mag_a = WIDTH'(twos_mag(MDU_MAX_W'(a), !unsig && a[WIDTH-1]));
   assign mag_b = WIDTH'(twos_mag(MDU_MAX_W'(b), !unsig && b[WIDTH-1]));
   assign raw   = acc[2*WIDTH-1:0];
   assign prod  = neg_p ? -raw : raw;
   assign quot  = neg_p ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
   assign rem   = neg_r ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
   assign busy  = state != S_IDLE;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .mode     (is_div),
      .acc      (acc),
      .operand  (opnd),
      .next_acc (step_acc),
      .qbit     (qbit)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         acc         <= '0;
         opnd        <= '0;
         a_orig      <= '0;
         is_div      <= 1'b0;
         neg_p       <= 1'b0;
         neg_r       <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               if (op == MDU_MTHI) begin
                  hi   <= a;
                  done <= !done;
               end else if (op == MDU_MTLO) begin
                  lo   <= a;
                  done <= !done;
               end else begin
                  is_div      <= op == MDU_DIV;
                  neg_p       <= !unsig && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r       <= !unsig && a[WIDTH-1];
                  a_orig      <= a;
                  opnd        <= (op == MDU_DIV) ? mag_b : mag_a;
                  acc         <= {{(WIDTH+1){1'b0}}, (op == MDU_DIV) ? mag_a : mag_b};
                  cnt         <= CNT_W'(WIDTH);
                  div_by_zero <= 1'b0;
                  state       <= S_RUN;
               end
            end
            S_RUN: if (cnt == '0) state <= S_FIX;
            else begin
               acc <= step_acc | {{(2*WIDTH){1'b0}}, qbit};
               cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               state <= S_IDLE;
               done  <= 1'b1;
               if (!is_div) {hi, lo} <= prod;
               else if (opnd == '0) begin
                  div_by_zero <= 1'b1;
                  hi          <= a_orig;
                  lo          <= '1;
               end else begin
                  hi <= rem;
                  lo <= quot;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks against an arithmetic reference model
module tb_mult_div_unit;
   import mdu_pkg::*;
   logic        clock = 1'b0, reset = 1'b1, start = 1'b0, unsig = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;
   int          checks = 0, failures = 0, cyc = 0, k0 = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .unsig       (unsig),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [1:0] o, input logic u, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] eh, output logic [31:0] el, output logic ez);
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ez = 1'b0;
      if (o == MDU_MULT) begin
         p = u ? {32'b0, x} * {32'b0, y} : 64'(sx * sy);
         {eh, el} = p;
      end else if (y == 0) begin
         ez = 1'b1;
         eh = x;
         el = '1;
      end else if (u) begin
         el = x / y;
         eh = x % y;
      end else begin
         q  = sx / sy;
         r  = sx % sy;
         el = q[31:0];
         eh = r[31:0];
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic u, input logic [31:0] x, input logic [31:0] y);
      @(negedge clock);
      start = 1'b1;
      op    = o;
      unsig = u;
      a     = x;
      b     = y;
      @(posedge clock);
      #1;
      k0    = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output logic dropped);
      lat     = -1;
      dropped = 1'b0;
      for (int j = 0; j < 60; j++) begin
         @(negedge clock);
         if (done) begin
            lat = cyc - k0;
            break;
         end
         if (!busy) dropped = 1'b1;
      end
   endtask

   task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el, input logic ez);
      int   lat;
      logic dropped;
      wait_done(lat, dropped);
      check({tag, "_lat"}, 64'(lat), 64'd34);
      check({tag, "_busy_run"}, 64'(dropped), 64'd0);
      check({tag, "_busy_done"}, 64'(busy), 64'd0);
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      check({tag, "_dz"}, 64'(div_by_zero), 64'(ez));
      @(negedge clock);
      check({tag, "_done_once"}, 64'(done), 64'd0);
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic u, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] eh, el;
      logic        ez;
      model(o, u, x, y, eh, el, ez);
      issue(o, u, x, y);
      finish_op(tag, eh, el, ez);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [31:0] eh, el;
      logic        ez, seen;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dz", 64'(div_by_zero), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);

      run("mulu_max", MDU_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("muls_m1m1", MDU_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("muls_m1x2", MDU_MULT, 1'b0, 32'hFFFF_FFFF, 32'h2);
      run("divs_m7", MDU_DIV, 1'b0, 32'hFFFF_FFF9, 32'h2);
      run("divu_m7", MDU_DIV, 1'b1, 32'hFFFF_FFF9, 32'h2);
      run("divu_z", MDU_DIV, 1'b1, 32'h7, 32'h0);
      run("divs_z", MDU_DIV, 1'b0, 32'hFFFF_FFF9, 32'h0);
      run("divs_min", MDU_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      run("muls_min", MDU_MULT, 1'b0, 32'h8000_0000, 32'h8000_0000);

      model(MDU_MULT, 1'b1, 32'd3, 32'd5, eh, el, ez);
      issue(MDU_MULT, 1'b1, 32'd3, 32'd5);
      repeat (4) @(negedge clock);
      start = 1'b1;
      op    = MDU_DIV;
      a     = 32'd9;
      b     = 32'd3;
      @(posedge clock);
      #1 start = 1'b0;
      finish_op("ignore", eh, el, ez);

      issue(MDU_MULT, 1'b1, 32'd3, 32'd5);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      seen = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clock);
         seen |= done;
      end
      check("abort_no_done", 64'(seen), 64'd0);

      issue(MDU_MTLO, 1'b0, 32'h1234_5678, 32'h0);
      @(negedge clock);
      check("mtlo_lo", 64'(lo), 64'h1234_5678);
      check("mtlo_done", 64'(done), 64'd1);
      check("mtlo_busy", 64'(busy), 64'd0);
      @(negedge clock);
      check("mtlo_done_once", 64'(done), 64'd0);
      issue(MDU_MTHI, 1'b0, 32'hCAFE_0001, 32'h0);
      @(negedge clock);
      check("mthi_hi", 64'(hi), 64'hCAFE_0001);
      check("mthi_lo_hold", 64'(lo), 64'h1234_5678);
      check("mthi_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 24; i++)
         run("rnd", 2'($urandom_range(0, 1)), 1'($urandom % 2), pick(), pick());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width.
- Sits beside the combinational ALU in the execute stage and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Uses the ALU's `unsig` convention: signed when low, unsigned when high.
- Multi-cycle: the pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration-counter width (derived; do not override).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- unsig  in  1  1 = unsigned operation, 0 = signed two's complement.
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in progress (RUN or FIX).
- done  out  1  one-cycle pulse when new HI/LO are visible.
- div_by_zero  out  1  sticky flag for the last DIV; cleared by the next accepted MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: clock and reset are already decided — one clock; reset is synchronous and active-high. On reset, state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0.
- Reset mid-operation aborts the operation; no partial result is written.
- FSM states:
  - IDLE: start with op=MULT/DIV latches a, b, op and unsig, then goes to RUN with the counter loaded to WIDTH. busy=1 from the next cycle.
  - IDLE, MTHI/MTLO: start with op=MTHI (MTLO) writes a into hi (lo) at that edge and stays in IDLE. done pulses the following cycle; busy stays 0.
  - RUN: one iteration per cycle, counter decrements, goes to FIX when the counter reaches 0.
  - FIX: applies sign correction, writes hi/lo, goes to IDLE. done=1 in the first IDLE cycle.
- Latency: start sampled at edge k. busy is high after edges k..k+WIDTH+1. hi/lo update and done=1 after edge k+WIDTH+2. This is WIDTH+2 cycles.
- start while busy is ignored: no queuing, and a, b, op and unsig are not re-sampled.
- Signed handling: operands are converted to magnitudes at latch. Note that |MIN| = 2^(WIDTH-1) fits unsigned.
  - Product is negated in FIX when signs differ.
  - Quotient is negated when signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
- MULT: shift-add over a 2*WIDTH accumulator; {hi,lo} = full 2*WIDTH product.
- DIV: restoring division; lo = quotient, hi = remainder.
- Divide by zero (b=0): runs the full latency, then div_by_zero=1, hi=a (original), lo=all ones, for both signed and unsigned.
- Signed MIN / -1: lo=MIN, hi=0 (wrap); no flag.
- hi/lo hold their values between operations. They change only in FIX, on MTHI/MTLO, or on reset.
- done is never high for two consecutive cycles.

Decomposition:
- Package mdu_pkg holds:
  - op encodings MDU_MULT, MDU_DIV, MDU_MTHI, MDU_MTLO;
  - state encodings S_IDLE, S_RUN, S_FIX;
  - a helper function for two's-complement magnitude.
- One sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator and quotient bit.
  - The top level keeps the FSM, counter and registers.

Test Plan:
- MULT, unsig=1, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT, unsig=0, a=0xFFFFFFFF (-1), b=0xFFFFFFFF (-1) -> hi=0x00000000, lo=0x00000001.
- MULT, unsig=0, a=0xFFFFFFFF (-1), b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV, unsig=0, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Same operands with unsig=1 -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV, unsig=1, a=7, b=0 -> div_by_zero=1, hi=7, lo=0xFFFFFFFF. DIV, unsig=0, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start MULT 3*5, then:
  - pulse start with DIV 9/3 at cycle 5 -> ignored; hi=0, lo=15.
  - repeat the MULT and assert reset at cycle 10 -> busy=0, hi=lo=0, no done pulse.
  - afterwards, MTLO a=0x12345678 -> lo=0x12345678 one cycle later, busy never asserted.
